// File: rtl/i2s_tx_multi.sv
// Multi-channel I2S / left-justified / TDM serial transmitter with a one-frame
// holding register, sticky underrun flag and strobe-driven mclk/sclk generation.
module i2s_tx_multi #(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32,
  parameter int NUM_CH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mclk_en,
  input  logic                     sclk_en,
  input  logic                     enable,
  input  logic                     mode,
  input  logic [NUM_CH*DATA_W-1:0] fifo_data,
  input  logic                     fifo_valid,
  output logic                     fifo_ready,
  output logic                     mclk,
  output logic                     sclk,
  output logic                     lrclk,
  output logic                     sdata,
  output logic                     underrun,
  input  logic                     underrun_clr
);

  localparam int FRAME = NUM_CH * SLOT_W;
  localparam int FW    = NUM_CH * DATA_W;
  localparam int BW    = $clog2(FRAME);
  localparam int JW    = $clog2(SLOT_W);

  localparam logic [BW-1:0] B_LAST = BW'(FRAME - 1);
  localparam logic [BW-1:0] B_SLOT = BW'(SLOT_W);
  localparam logic [BW-1:0] B_ONE  = BW'(1);
  localparam logic [BW-1:0] B_ZERO = '0;
  localparam logic [JW-1:0] J_LAST = JW'(SLOT_W - 1);
  localparam logic [JW-1:0] J_ONE  = JW'(1);
  localparam logic [JW:0]   J_DATA = (JW+1)'(DATA_W);

  logic          r_mclk;
  logic          r_sclk;
  logic          r_lrclk;
  logic          r_sdata;
  logic          r_ready;
  logic          r_full;
  logic          r_under;
  logic          r_mode;
  logic [BW-1:0] r_b;
  logic [JW-1:0] r_j;
  logic [FW-1:0] r_hold;
  logic [FW-1:0] r_shift;

  logic          w_fall;
  logic [BW-1:0] w_b_next;
  logic          w_start;
  logic          w_take;
  logic          w_full_next;
  logic [JW-1:0] w_j_next;
  logic          w_in_data;
  logic          w_lr_next;

  always_comb begin
    w_fall      = enable & sclk_en & r_sclk;
    w_b_next    = (r_b == B_LAST) ? B_ZERO : r_b + B_ONE;
    // Channel-0 MSB position: b=0 left-justified, b=1 for I2S one-bit delay.
    w_start     = w_fall & (w_b_next == (r_mode ? B_ZERO : B_ONE));
    w_take      = fifo_valid & r_ready;
    w_full_next = w_take | (r_full & ~w_start);
    // r_j is the bit index within the slot of the bit now being driven.
    if (w_start)
      w_j_next = '0;
    else if (r_j == J_LAST)
      w_j_next = '0;
    else
      w_j_next = r_j + J_ONE;
    w_in_data   = ({1'b0, w_j_next} < J_DATA);
  end

  generate
    if (NUM_CH == 2) begin : g_lr_stereo
      assign w_lr_next = r_mode ? (w_b_next < B_SLOT) : (w_b_next >= B_SLOT);
    end else begin : g_lr_tdm
      assign w_lr_next = (w_b_next == B_ZERO);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mclk  <= 1'b0;
      r_sclk  <= 1'b0;
      r_lrclk <= 1'b0;
      r_sdata <= 1'b0;
      r_ready <= 1'b0;
      r_full  <= 1'b0;
      r_under <= 1'b0;
      r_mode  <= 1'b0;
      r_b     <= B_LAST;
      r_j     <= J_LAST;
      r_hold  <= '0;
      r_shift <= '0;
    end else begin
      if (mclk_en)
        r_mclk <= ~r_mclk;

      if (!enable)
        r_sclk <= 1'b0;
      else if (sclk_en)
        r_sclk <= ~r_sclk;

      if (!enable) begin
        r_mode  <= mode;
        r_b     <= B_LAST;
        r_j     <= J_LAST;
        r_lrclk <= 1'b0;
        r_sdata <= 1'b0;
        r_shift <= '0;
      end else if (w_fall) begin
        r_b     <= w_b_next;
        r_j     <= w_j_next;
        r_lrclk <= w_lr_next;
        if (w_start) begin
          r_sdata <= r_full & r_hold[FW-1];
          r_shift <= r_full ? {r_hold[FW-2:0], 1'b0} : '0;
        end else if (w_in_data) begin
          r_sdata <= r_shift[FW-1];
          r_shift <= {r_shift[FW-2:0], 1'b0};
        end else begin
          r_sdata <= 1'b0;
        end
      end

      // A handshake on the frame-start cycle lands in the now-free holding register.
      if (w_take)
        r_hold <= fifo_data;
      r_full  <= w_full_next;
      r_ready <= ~w_full_next;

      if (w_start & ~r_full)
        r_under <= 1'b1;
      else if (underrun_clr)
        r_under <= 1'b0;
    end
  end

  assign fifo_ready = r_ready;
  assign mclk       = r_mclk;
  assign sclk       = r_sclk;
  assign lrclk      = r_lrclk;
  assign sdata      = r_sdata;
  assign underrun   = r_under;

endmodule

// File: tb/tb_i2s_tx_multi.sv
// Directed bench for i2s_tx_multi: stereo I2S/left-justified instance plus a
// 4-channel TDM instance, with hand-computed expected bit patterns.
module tb_i2s_tx_multi;

  logic        clk;
  logic        rst_n;
  logic        mclk_en;
  logic        sclk_en;
  logic        mode;
  logic        underrun_clr;

  logic        enable_a, fifo_valid_a, fifo_ready_a;
  logic [47:0] fifo_data_a;
  logic        mclk_a, sclk_a, lrclk_a, sdata_a, underrun_a;

  logic        enable_b, fifo_valid_b, fifo_ready_b;
  logic [63:0] fifo_data_b;
  logic        mclk_b, sclk_b, lrclk_b, sdata_b, underrun_b;

  int          n_vec = 0;
  int          n_err = 0;
  logic        cap_lr [0:255];
  logic        cap_sd [0:255];
  logic [47:0] frames [4];
  bit          cap_done;
  int          hs;
  logic [64:0] ev;

  i2s_tx_multi u_dut_a (
    .clk(clk), .rst_n(rst_n), .mclk_en(mclk_en), .sclk_en(sclk_en),
    .enable(enable_a), .mode(mode), .fifo_data(fifo_data_a),
    .fifo_valid(fifo_valid_a), .fifo_ready(fifo_ready_a),
    .mclk(mclk_a), .sclk(sclk_a), .lrclk(lrclk_a), .sdata(sdata_a),
    .underrun(underrun_a), .underrun_clr(underrun_clr)
  );

  i2s_tx_multi #(.DATA_W(16), .SLOT_W(16), .NUM_CH(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .mclk_en(mclk_en), .sclk_en(sclk_en),
    .enable(enable_b), .mode(mode), .fifo_data(fifo_data_b),
    .fifo_valid(fifo_valid_b), .fifo_ready(fifo_ready_b),
    .mclk(mclk_b), .sclk(sclk_b), .lrclk(lrclk_b), .sdata(sdata_b),
    .underrun(underrun_b), .underrun_clr(underrun_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // sclk_en high every other clk, changed well away from both clock edges
  initial begin
    sclk_en = 1'b0;
    forever begin
      @(posedge clk);
      #2 sclk_en = ~sclk_en;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %-16s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %-16s %h", tag, got);
    end
  endtask

  function automatic logic [63:0] pack(input bit lr, input int lo, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++)
      r = {r[62:0], (lr ? cap_lr[lo+i] : cap_sd[lo+i])};
    return r;
  endfunction

  // Wait for the next falling event of the selected DUT and record lrclk/sdata.
  task automatic next_bit(input bit sel, input int idx);
    int n;
    n = 0;
    @(negedge clk);
    while (!(sclk_en && (sel ? sclk_b : sclk_a)) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40)
      chk("fall_wait", 64'(n), 64'd39);
    @(posedge clk);
    #1;
    cap_lr[idx] = sel ? lrclk_b : lrclk_a;
    cap_sd[idx] = sel ? sdata_b : sdata_a;
  endtask

  task automatic capture(input bit sel, input int n);
    for (int i = 0; i < n; i++)
      next_bit(sel, i);
  endtask

  task automatic push(input bit sel, input logic [63:0] d);
    int n;
    n = 0;
    @(negedge clk);
    if (sel) begin
      fifo_data_b  = d;
      fifo_valid_b = 1'b1;
    end else begin
      fifo_data_a  = d[47:0];
      fifo_valid_a = 1'b1;
    end
    while (!(sel ? fifo_ready_b : fifo_ready_a) && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    fifo_valid_a = 1'b0;
    fifo_valid_b = 1'b0;
    chk(sel ? "ready_drop_b" : "ready_drop_a",
        64'(sel ? fifo_ready_b : fifo_ready_a), 64'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    mclk_en      = 1'b1;
    mode         = 1'b0;
    underrun_clr = 1'b0;
    enable_a     = 1'b0;
    enable_b     = 1'b0;
    fifo_valid_a = 1'b0;
    fifo_valid_b = 1'b0;
    fifo_data_a  = '0;
    fifo_data_b  = '0;
    cap_done     = 1'b0;
    hs           = 0;
    frames[0]    = 48'h123456_789ABC;
    frames[1]    = 48'hFEDCBA_987654;
    frames[2]    = 48'h0F0F0F_F0F0F0;
    frames[3]    = 48'h3C3C3C_C3C3C3;

    // reset state and release
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {58'd0, mclk_a, sclk_a, lrclk_a, sdata_a, fifo_ready_a, underrun_a}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 64'(fifo_ready_a), 64'd1);
    chk("mclk_first", 64'(mclk_a), 64'd1);
    @(posedge clk);
    #1;
    chk("mclk_toggle", 64'(mclk_a), 64'd0);

    // I2S mode, one frame plus b=0 of the next
    mode = 1'b0;
    repeat (2) @(posedge clk);
    push(1'b0, 64'h0000_A5A5A5_5A5A5A);
    @(negedge clk);
    enable_a = 1'b1;
    capture(1'b0, 65);
    enable_a = 1'b0;
    chk("m0_lr", pack(1'b1, 0, 64), 64'h0000_0000_FFFF_FFFF);
    chk("m0_sd", pack(1'b0, 0, 64), {1'b0, 24'hA5A5A5, 8'h00, 24'h5A5A5A, 7'h00});
    chk("m0_wrap_sd", 64'(cap_sd[64]), 64'd0);
    chk("m0_no_underrun", 64'(underrun_a), 64'd0);
    chk("m0_ready", 64'(fifo_ready_a), 64'd1);

    // left-justified mode
    mode = 1'b1;
    repeat (2) @(posedge clk);
    push(1'b0, 64'h0000_A5A5A5_5A5A5A);
    @(negedge clk);
    enable_a = 1'b1;
    capture(1'b0, 64);
    enable_a = 1'b0;
    chk("m1_lr", pack(1'b1, 0, 64), 64'hFFFF_FFFF_0000_0000);
    chk("m1_sd", pack(1'b0, 0, 64), {24'hA5A5A5, 8'h00, 24'h5A5A5A, 8'h00});

    // underrun: empty holding register
    @(negedge clk);
    enable_a = 1'b1;
    capture(1'b0, 64);
    chk("ur_sd_zero", pack(1'b0, 0, 64), 64'd0);
    chk("ur_set", 64'(underrun_a), 64'd1);
    underrun_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("ur_clr", 64'(underrun_a), 64'd0);
    next_bit(1'b0, 0);
    chk("ur_set_prio", 64'(underrun_a), 64'd1);
    chk("ur_b0_lr", 64'(cap_lr[0]), 64'd1);
    underrun_clr = 1'b0;
    enable_a = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_outs", {61'd0, sclk_a, lrclk_a, sdata_a}, 64'd0);
    chk("ur_sticky", 64'(underrun_a), 64'd1);
    underrun_clr = 1'b1;
    @(posedge clk);
    #1;
    underrun_clr = 1'b0;

    // back-to-back frames with fifo_valid held high
    push(1'b0, {16'h0, frames[0]});
    hs = 1;
    cap_done = 1'b0;
    fork
      begin
        @(negedge clk);
        enable_a = 1'b1;
        capture(1'b0, 192);
        cap_done = 1'b1;
        enable_a = 1'b0;
      end
      begin
        @(negedge clk);
        fifo_data_a  = frames[1];
        fifo_valid_a = 1'b1;
        while (!cap_done) begin
          @(negedge clk);
          if (!cap_done && fifo_ready_a) begin
            @(posedge clk);
            #1;
            hs++;
            fifo_data_a = frames[hs % 4];
          end
        end
        fifo_valid_a = 1'b0;
      end
    join
    for (int f = 0; f < 3; f++)
      chk($sformatf("b2b_frame%0d", f), pack(1'b0, f*64, 64),
          {frames[f][47:24], 8'h00, frames[f][23:0], 8'h00});
    chk("b2b_accepts", 64'(hs), 64'd4);
    chk("b2b_no_underrun", 64'(underrun_a), 64'd0);

    // reset mid-frame at b=40; held frame (frames[3]) survived the enable drop
    mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    enable_a = 1'b1;
    capture(1'b0, 41);
    chk("kept_hold_L", pack(1'b0, 1, 24), {40'd0, frames[3][47:24]});
    rst_n = 1'b0;
    #1;
    chk("rst_async", {58'd0, mclk_a, sclk_a, lrclk_a, sdata_a, fifo_ready_a, underrun_a}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_release", 64'(fifo_ready_a), 64'd1);
    fork
      push(1'b0, 64'h0000_0F1E2D_3C4B5A);
      capture(1'b0, 64);
    join
    enable_a = 1'b0;
    chk("rst_lr", pack(1'b1, 0, 64), 64'h0000_0000_FFFF_FFFF);
    chk("rst_sd", pack(1'b0, 0, 64), {1'b0, 24'h0F1E2D, 8'h00, 24'h3C4B5A, 7'h00});

    // 4-channel TDM, I2S delay, frame-sync pulse
    push(1'b1, 64'h8001_4002_2004_1008);
    @(negedge clk);
    enable_b = 1'b1;
    capture(1'b1, 65);
    enable_b = 1'b0;
    ev = {1'b0, 64'h8001_4002_2004_1008};
    chk("tdm_lr", pack(1'b1, 0, 64), 64'h8000_0000_0000_0000);
    chk("tdm_lr_next", 64'(cap_lr[64]), 64'd1);
    chk("tdm_sd", pack(1'b0, 0, 64), ev[64:1]);
    chk("tdm_ch3_lsb", 64'(cap_sd[64]), 64'(ev[0]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_tx_multi.md
I2S_TX_MULTI -- requirements
Module: i2s_tx_multi

Interface
REQ-001 The block SHALL have parameter DATA_W, default 24, sample width in bits (8..32).
REQ-002 The block SHALL have parameter SLOT_W, default 32, bit clocks per channel slot; DATA_W <= SLOT_W is required.
REQ-003 The block SHALL have parameter NUM_CH, default 2, channels per frame (2..8); FRAME = NUM_CH*SLOT_W.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, as follows.
REQ-005 clk  in  1  system clock; all logic on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 mclk_en  in  1  single-cycle strobe; toggles mclk.
REQ-008 sclk_en  in  1  single-cycle strobe; toggles sclk.
REQ-009 enable  in  1  1 = transmit frames; 0 = serial port idle.
REQ-010 mode  in  1  0 = I2S (one-bit delay); 1 = left-justified; sampled only while enable = 0.
REQ-011 fifo_data  in  NUM_CH*DATA_W  one frame; channel k at bits [(NUM_CH-k)*DATA_W-1 -: DATA_W] (channel 0 in the MSBs).
REQ-012 fifo_valid  in  1  fifo_data valid.
REQ-013 fifo_ready  out  1  holding register empty; accepts a frame.
REQ-014 mclk, sclk, lrclk, sdata  out  1 each  I2S/TDM serial outputs.
REQ-015 underrun  out  1  sticky: a frame was sent without data.
REQ-016 underrun_clr  in  1  clears underrun.

Function
REQ-017 A falling event SHALL be a clk cycle with sclk_en = 1 and sclk = 1; lrclk, sdata and bit counter b (0..FRAME-1) SHALL change only on falling events.
REQ-018 mclk SHALL toggle on every mclk_en regardless of enable; sclk SHALL toggle on sclk_en only while enable = 1, else SHALL be held 0.
REQ-019 While enable = 0: b SHALL be held at FRAME-1, lrclk = 0, sdata = 0, shift register cleared; the first falling event after enable rises SHALL move b to 0.
REQ-020 b SHALL increment by 1 per falling event, wrapping FRAME-1 -> 0.
REQ-021 NUM_CH = 2, mode 0: lrclk = 1 for b >= SLOT_W, else 0; mode 1: lrclk = 1 for b < SLOT_W, else 0.
REQ-022 NUM_CH > 2: lrclk SHALL be 1 only at b = 0 (one-bit frame-sync pulse), both modes.
REQ-023 Channel s MSB SHALL appear at b = s*SLOT_W (mode 1) or b = s*SLOT_W+1 (mode 0), followed by DATA_W-1 bits MSB-first, then SLOT_W-DATA_W zero bits.
REQ-024 In mode 0, the last bit of channel NUM_CH-1 SHALL appear at b = 0 of the following frame (continuous stream).
REQ-025 Holding register SHALL load on any cycle with fifo_valid = 1 and fifo_ready = 1; fifo_ready SHALL be registered, deasserting the cycle after acceptance.
REQ-026 At the channel-0 MSB falling event, if the holding register is full, its contents SHALL move to the shift register and fifo_ready SHALL reassert the next cycle; a same-cycle handshake SHALL be ignored for that frame and accepted for the next.
REQ-027 If the holding register is empty at that event, the frame SHALL be sent as all zeros and underrun SHALL set the next cycle.
REQ-028 underrun_clr SHALL clear underrun; a simultaneous set SHALL take priority.
REQ-029 Dropping enable mid-frame SHALL abort the frame at once (REQ-019); holding register contents SHALL be kept.

Reset
REQ-030 While rst_n = 0: mclk, sclk, lrclk, sdata, fifo_ready, underrun = 0; b = FRAME-1; holding register empty; shift register cleared.
REQ-031 fifo_ready SHALL assert on the first clk edge after rst_n deasserts; reset SHALL take effect immediately, even mid-frame.

Verification
REQ-032 Defaults, mode 0, frame L=0xA5A5A5 R=0x5A5A5A, sclk_en every 2 clks -> lrclk low 32 bits / high 32 bits; L MSB at b=1, bits 25..32 zero; R MSB at b=33.
REQ-033 Same frame in mode 1 -> L MSB at b=0 coinciding with lrclk rise; R MSB at b=32 on lrclk fall.
REQ-034 NUM_CH=4, SLOT_W=16, DATA_W=16, mode 0, ch0..3 = 0x8001,0x4002,0x2004,0x1008 -> one-bit lrclk pulse at b=0; ch3 LSB at b=0 of next frame.
REQ-035 fifo_valid low for one frame -> 64 zero bits, underrun=1; underrun_clr -> 0; simultaneous clr and new underrun -> stays 1.
REQ-036 Back-to-back frames with fifo_valid held 1 -> exactly one acceptance per frame, no zero gaps between frames.
REQ-037 rst_n pulse at b=40 -> all outputs 0 at once; ready=1 one clk after release; next frame starts at b=0 with fresh data.
